key_debounce: RTL and testbench

- Upstream input stage for the board LED blocks. It conditions one raw, bouncing, active-low push-button into clean single-cycle events and a stable level.
- LED pattern and speed logic consume the events to change mode or rate.
- It synchronises the asynchronous key, debounces press and release with a counter-based FSM, and flags a long press.

---
 rtl/key_debounce_pkg.sv | 13 +
 rtl/key_debounce_if.sv | 34 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/key_debounce.sv | 133 +++++++++++++
 tb/tb_key_debounce.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Purpose: shared constants and helpers for the push-button input stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_debounce_pkg;

   // Board system clock; used to set CLK_FREQ where key_debounce is instantiated.
   localparam int CLK_FREQ_HZ = 27_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Purpose: bundles the raw key input and the conditioned key events/level.
// Latency: n/a (wiring only).
// Backpressure: none; events are one-cycle pulses with no ready, sink must sample every cycle.
//
// Signals:
//   key_in      raw push-button level, asynchronous to the clock
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse on an accepted press
//   key_release one-cycle pulse on an accepted release
//   key_long    one-cycle pulse, at most once per press, on a long hold
// master = board/button side, slave = the debouncer.
interface key_debounce_if;
   logic key_in;
   logic key_state;
   logic key_press;
   logic key_release;
   logic key_long;

   modport master (
      output key_in,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_state,
      output key_press,
      output key_release,
      output key_long
   );
endinterface

// File: rtl/sync_2ff.sv
// Purpose: generic two-flop synchroniser for asynchronous inputs, reset value selectable.
// Latency: 2 clk edges from input change to output.
// Backpressure: none; free-running sampler.
//
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronised output).
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Purpose: turns one raw bouncing push-button into a debounced level plus press/release/long pulses.
// Latency: press/release pulse DB_CYC+2 edges after the first edge sampling the new stable level.
// Backpressure: none; outputs are registered pulses/level with no ready.
//
// Ports: clk, rst_n (async active-low), kif (slave modport: key_in in; key_state,
// key_press, key_release, key_long out).
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int   CLK_FREQ    = CLK_FREQ_HZ,
   parameter int   DEBOUNCE_MS = 20,
   parameter int   LONG_MS     = 1000,
   parameter logic KEY_ACTIVE  = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   key_debounce_if.slave  kif
);

   localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
   localparam int CNT_W    = max_int(1, $clog2(max_int(DB_CYC, LONG_CYC)));

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic [CNT_W-1:0] long_cnt_q;
   logic [CNT_W-1:0] long_cnt_d;
   logic             long_done_q;
   logic             key_state_q;
   logic             press_q;
   logic             release_q;
   logic             long_q;
   logic             key_s2;
   logic             act;

   // Reset to the inactive level so a key held through reset still shows a fresh edge.
   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (~KEY_ACTIVE)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (kif.key_in),
      .q_o   (key_s2)
   );

   assign act = (key_s2 == KEY_ACTIVE);

   // Hold counter saturates so a very long press never re-arms key_long by wrapping.
   assign long_cnt_d = (long_cnt_q == LONG_LAST) ? long_cnt_q : long_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         long_cnt_q  <= '0;
         long_done_q <= 1'b0;
         key_state_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (act) begin
                  state_q  <= PRESS_DB;
                  db_cnt_q <= '0;
               end
            end
            PRESS_DB: begin
               if (!act) begin
                  state_q  <= IDLE;
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q     <= HELD;
                  press_q     <= 1'b1;
                  key_state_q <= 1'b1;
                  long_cnt_q  <= '0;
                  long_done_q <= 1'b0;
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!act) begin
                  // Hold time is frozen (not cleared) so a rejected release bounce
                  // does not restart the long-press measurement.
                  state_q  <= RELEASE_DB;
                  db_cnt_q <= '0;
               end else begin
                  long_cnt_q <= long_cnt_d;
                  if (long_cnt_q == LONG_LAST && !long_done_q) begin
                     long_q      <= 1'b1;
                     long_done_q <= 1'b1;
                  end
               end
            end
            RELEASE_DB: begin
               if (act) begin
                  state_q <= HELD;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q     <= IDLE;
                  release_q   <= 1'b1;
                  key_state_q <= 1'b0;
                  db_cnt_q    <= '0;
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign kif.key_state   = key_state_q;
   assign kif.key_press   = press_q;
   assign kif.key_release = release_q;
   assign kif.key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: directed self-checking bench for key_debounce (1 kHz clock model, 1 ms = 1 cycle).
// Latency: n/a.
// Backpressure: n/a.
module tb_key_debounce;

   logic clk;
   logic rst_n;
   key_debounce_if kif ();

   key_debounce #(
      .CLK_FREQ    (1000),
      .DEBOUNCE_MS (20),
      .LONG_MS     (100),
      .KEY_ACTIVE  (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   int n_assert    = 0;
   int n_fail      = 0;
   int cyc         = 0;
   int press_cnt   = 0;
   int release_cnt = 0;
   int long_cnt    = 0;
   int st_cnt      = 0;
   int press_cyc   = -1;
   int release_cyc = -1;
   int long_cyc    = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Event recorder, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (kif.key_press === 1'b1) begin
         press_cnt++;
         press_cyc = cyc;
      end
      if (kif.key_release === 1'b1) begin
         release_cnt++;
         release_cyc = cyc;
      end
      if (kif.key_long === 1'b1) begin
         long_cnt++;
         long_cyc = cyc;
      end
      if (kif.key_state === 1'b1) st_cnt++;
      n_assert++;
      assert ($onehot0({kif.key_press, kif.key_release, kif.key_long})) else begin
         n_fail++;
         $error("FAIL excl: press/release/long = %b%b%b, required at most one high",
                kif.key_press, kif.key_release, kif.key_long);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int t0, t1, tr, p0, r0, l0, s0;
      int lows [6] = '{8, 15, 4, 19, 11, 2};

      rst_n      = 1'b1;
      kif.key_in = 1'b1;
      #2 rst_n   = 1'b0;
      tick(3);
      check("rst_state",   kif.key_state,   1'b0);
      check("rst_press",   kif.key_press,   1'b0);
      check("rst_release", kif.key_release, 1'b0);
      check("rst_long",    kif.key_long,    1'b0);
      rst_n = 1'b1;
      tick(5);
      check("idle_state", kif.key_state, 1'b0);
      check("idle_press_cnt", press_cnt, 0);

      // Clean press held 200 cycles, then clean release.
      kif.key_in = 1'b0;
      t0 = cyc;
      tick(22);
      check("clean_state_early", kif.key_state, 1'b0);
      check("clean_press_early", kif.key_press, 1'b0);
      tick(1);
      check("clean_press_edge", kif.key_press, 1'b1);
      check("clean_state_edge", kif.key_state, 1'b1);
      tick(1);
      check("clean_press_width", kif.key_press, 1'b0);
      tick(176);
      check("clean_press_cnt", press_cnt, 1);
      check("clean_press_cyc", press_cyc, t0 + 23);
      check("clean_long_cnt",  long_cnt, 1);
      check("clean_long_cyc",  long_cyc, t0 + 123);
      check("clean_rel_none",  release_cnt, 0);
      kif.key_in = 1'b1;
      t1 = cyc;
      tick(30);
      check("clean_rel_cnt",   release_cnt, 1);
      check("clean_rel_cyc",   release_cyc, t1 + 23);
      check("clean_rel_state", kif.key_state, 1'b0);
      check("clean_long_once", long_cnt, 1);

      // Bounce rejection: 5, 12, 19 cycle lows with 3-cycle highs.
      tick(5);
      p0 = press_cnt; r0 = release_cnt; s0 = st_cnt;
      kif.key_in = 1'b0; tick(5);
      kif.key_in = 1'b1; tick(3);
      kif.key_in = 1'b0; tick(12);
      kif.key_in = 1'b1; tick(3);
      kif.key_in = 1'b0; tick(19);
      kif.key_in = 1'b1; tick(40);
      check("bounce_press",   press_cnt, p0);
      check("bounce_release", release_cnt, r0);
      check("bounce_state",   st_cnt, s0);

      // Bouncy press then stable low; short hold, no long.
      l0 = long_cnt;
      for (int i = 0; i < 6; i++) begin
         kif.key_in = 1'b0; tick(lows[i]);
         kif.key_in = 1'b1; tick(3);
      end
      kif.key_in = 1'b0;
      t0 = cyc;
      tick(30);
      check("bouncy_press_cnt", press_cnt, p0 + 1);
      check("bouncy_press_cyc", press_cyc, t0 + 23);
      kif.key_in = 1'b1;
      tick(30);
      check("bouncy_rel_cnt", release_cnt, r0 + 1);

      // Short press: 50 cycles low.
      p0 = press_cnt; r0 = release_cnt;
      kif.key_in = 1'b0;
      t0 = cyc;
      tick(50);
      kif.key_in = 1'b1;
      t1 = cyc;
      tick(40);
      check("short_press_cnt", press_cnt, p0 + 1);
      check("short_press_cyc", press_cyc, t0 + 23);
      check("short_rel_cnt",   release_cnt, r0 + 1);
      check("short_rel_cyc",   release_cyc, t1 + 23);
      check("short_no_long",   long_cnt, l0);

      // Release bounce during hold; hold time freezes for the bounce, then resumes.
      p0 = press_cnt; r0 = release_cnt;
      kif.key_in = 1'b0;
      t0 = cyc;
      tick(40);
      kif.key_in = 1'b1;
      tick(10);
      check("rbounce_state_mid", kif.key_state, 1'b1);
      kif.key_in = 1'b0;
      tick(110);
      check("rbounce_no_rel",  release_cnt, r0);
      check("rbounce_state",   kif.key_state, 1'b1);
      check("rbounce_press",   press_cnt, p0 + 1);
      check("rbounce_long_cnt", long_cnt, l0 + 1);
      check("rbounce_long_cyc", long_cyc, t0 + 134);
      kif.key_in = 1'b1;
      t1 = cyc;
      tick(30);
      check("rbounce_rel_cnt", release_cnt, r0 + 1);
      check("rbounce_rel_cyc", release_cyc, t1 + 23);

      // Reset mid-debounce with key still low, then fresh full latency.
      p0 = press_cnt; r0 = release_cnt;
      kif.key_in = 1'b0;
      tick(13);
      rst_n = 1'b0;
      #1;
      check("mrst_state",   kif.key_state,   1'b0);
      check("mrst_press",   kif.key_press,   1'b0);
      check("mrst_release", kif.key_release, 1'b0);
      check("mrst_long",    kif.key_long,    1'b0);
      tick(2);
      rst_n = 1'b1;
      tr = cyc;
      tick(30);
      check("mrst_press_cnt", press_cnt, p0 + 1);
      check("mrst_press_cyc", press_cyc, tr + 23);
      check("held_state_pre", kif.key_state, 1'b1);

      // Reset while held: level drops at once, no release pulse afterwards.
      rst_n = 1'b0;
      #1;
      check("hrst_state", kif.key_state, 1'b0);
      kif.key_in = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(30);
      check("hrst_no_rel",   release_cnt, r0);
      check("hrst_state_end", kif.key_state, 1'b0);
      check("hrst_no_press", press_cnt, p0 + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
